// File: rtl/debug_ctrl.sv
// debug_ctrl: UART-side debug controller (load, run, single-step, snapshot send).
// Optional hardware breakpoint compiled in with `define DBG_BREAKPOINT_EN.
module debug_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int INSTR_BYTES = 4,
    parameter int SNAP_BYTES  = 320,
    parameter int CNT_BYTES   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 i_rx_data,
    input  logic                       i_rx_done,
    input  logic                       i_tx_done,
    input  logic [SNAP_BYTES*8-1:0]    i_snapshot,
    input  logic [ADDR_W-1:0]          i_pc,
    input  logic                       i_halt,
    output logic                       o_step,
    output logic                       o_pipe_rst_n,
    output logic [ADDR_W-1:0]          o_addr,
    output logic [INSTR_BYTES*8-1:0]   o_instr,
    output logic                       o_we,
    output logic [7:0]                 o_tx_data,
    output logic                       o_tx_start,
    output logic                       o_idle
);
    localparam int CNT_W = CNT_BYTES * 8;
    localparam int FB    = SNAP_BYTES + CNT_BYTES;
    localparam int FW    = $clog2(FB);
    localparam int BW    = $clog2(INSTR_BYTES + 1);
    localparam logic [FW-1:0] LAST_F = FW'(FB - 1);
    localparam logic [BW-1:0] LAST_B = BW'(INSTR_BYTES - 1);

    typedef enum logic [3:0] {
        IDLE, LD_CNT, LD_DATA, LD_WR, RUN, ST_WAIT, ST_PULSE,
`ifdef DBG_BREAKPOINT_EN
        BP_ADDR,
`endif
        SEND, SEND_WAIT
    } state_t;

    state_t state, next;

    logic [CNT_W-1:0]  cnt;
    logic [7:0]        ld_left;
    logic [BW-1:0]     b_cnt;
    logic [FW-1:0]     f_idx;
    logic [FW-1:0]     f_nxt;
    logic              ret_step;
    logic              bp_hit;
    logic [FB*8-1:0]   frame;

    assign frame = {cnt, i_snapshot};
    assign f_nxt = f_idx + 1'b1;

`ifdef DBG_BREAKPOINT_EN
    localparam int BPB = (ADDR_W + 7) / 8;
    localparam int PW  = $clog2(BPB + 1);
    localparam logic [PW-1:0] LAST_P = PW'(BPB - 1);

    logic [BPB*8-1:0] bp;
    logic [PW-1:0]    bp_cnt;
    logic             bp_run;

    assign bp_hit = bp_run && (i_pc == bp[ADDR_W-1:0]);

    // Breakpoint address capture, LSB first; armed only for a 0x04 run.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bp     <= '0;
            bp_cnt <= '0;
            bp_run <= 1'b0;
        end else if (state == IDLE) begin
            bp_cnt <= '0;
            bp_run <= 1'b0;
        end else if (state == BP_ADDR && i_rx_done) begin
            bp[{bp_cnt, 3'b000} +: 8] <= i_rx_data;
            bp_cnt <= bp_cnt + 1'b1;
            if (bp_cnt == LAST_P) bp_run <= 1'b1;
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^i_pc;
    assign bp_hit    = 1'b0;
`endif

    // Pipeline clock enable: free run gated by halt/breakpoint, or one step.
    always_comb begin
        o_step = 1'b0;
        if (state == ST_PULSE) o_step = 1'b1;
        else if (state == RUN) o_step = !i_halt && !bp_hit;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= next;
    end

    // Next-state decode.
    always_comb begin
        next = state;
        case (state)
            IDLE: if (i_rx_done) begin
                case (i_rx_data)
                    8'h01:   next = LD_CNT;
                    8'h02:   next = RUN;
                    8'h03:   next = ST_WAIT;
`ifdef DBG_BREAKPOINT_EN
                    8'h04:   next = BP_ADDR;
`endif
                    default: next = IDLE;
                endcase
            end
            LD_CNT:  if (i_rx_done) next = (i_rx_data == 8'h00) ? IDLE : LD_DATA;
            LD_DATA: if (i_rx_done && b_cnt == LAST_B) next = LD_WR;
            LD_WR:   next = (ld_left == 8'd1) ? IDLE : LD_DATA;
            RUN:     if (!o_step) next = SEND;
            ST_WAIT: if (i_rx_done) begin
                if (i_rx_data == 8'h03) next = i_halt ? SEND : ST_PULSE;
                else if (i_rx_data == 8'h06) next = IDLE;
            end
            ST_PULSE: next = SEND;
`ifdef DBG_BREAKPOINT_EN
            BP_ADDR: if (i_rx_done && bp_cnt == LAST_P) next = RUN;
`endif
            SEND:    next = SEND_WAIT;
            SEND_WAIT: if (i_tx_done && f_idx == LAST_F)
                next = ret_step ? ST_WAIT : IDLE;
            default: next = IDLE;
        endcase
    end

    // Datapath: counter, load assembly, frame streaming, registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt          <= '0;
            ld_left      <= '0;
            b_cnt        <= '0;
            f_idx        <= '0;
            ret_step     <= 1'b0;
            o_addr       <= '0;
            o_instr      <= '0;
            o_we         <= 1'b0;
            o_tx_data    <= '0;
            o_tx_start   <= 1'b0;
            o_idle       <= 1'b1;
            o_pipe_rst_n <= 1'b0;
        end else begin
            o_we         <= (next == LD_WR);
            o_idle       <= (next == IDLE);
            o_pipe_rst_n <= !(next inside {IDLE, LD_CNT, LD_DATA, LD_WR});
            o_tx_start   <= 1'b0;
            if (state == IDLE && next != IDLE && next != LD_CNT)
                cnt <= '0;
            else if (o_step && cnt != '1)
                cnt <= cnt + 1'b1;
            if (state == IDLE && next == LD_CNT)
                o_addr <= '0;
            if (state == LD_CNT && i_rx_done) begin
                ld_left <= i_rx_data;
                b_cnt   <= '0;
            end
            if (state == LD_DATA && i_rx_done) begin
                o_instr[{b_cnt, 3'b000} +: 8] <= i_rx_data;
                b_cnt <= (b_cnt == LAST_B) ? '0 : b_cnt + 1'b1;
            end
            if (state == LD_WR) begin
                o_addr  <= o_addr + 1'b1;
                ld_left <= ld_left - 1'b1;
            end
            if (next == SEND && state != SEND) begin
                f_idx    <= '0;
                ret_step <= (state == ST_PULSE);
            end
            if (state == SEND) begin
                o_tx_start <= 1'b1;
                o_tx_data  <= frame[{f_idx, 3'b000} +: 8];
            end
            if (state == SEND_WAIT && i_tx_done && f_idx != LAST_F) begin
                f_idx      <= f_nxt;
                o_tx_start <= 1'b1;
                o_tx_data  <= frame[{f_nxt, 3'b000} +: 8];
            end
        end
    end
endmodule

// File: tb/tb_debug_ctrl.sv
// tb_debug_ctrl: vector table, directed corner sequences and randomized
// load/run/step traffic against a frame/memory reference model.
module tb_debug_ctrl;
    localparam int ADDR_W      = 8;
    localparam int INSTR_BYTES = 4;
    localparam int SNAP_BYTES  = 320;
    localparam int CNT_BYTES   = 4;
    localparam int FB          = SNAP_BYTES + CNT_BYTES;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic [7:0]               i_rx_data = '0;
    logic                     i_rx_done = 1'b0;
    logic                     i_tx_done = 1'b0;
    logic [SNAP_BYTES*8-1:0]  snap = '0;
    logic [ADDR_W-1:0]        pc = '0;
    logic                     i_halt = 1'b0;
    logic                     o_step, o_pipe_rst_n, o_we, o_tx_start, o_idle;
    logic [ADDR_W-1:0]        o_addr;
    logic [INSTR_BYTES*8-1:0] o_instr;
    logic [7:0]               o_tx_data;

    debug_ctrl #(
        .ADDR_W(ADDR_W), .INSTR_BYTES(INSTR_BYTES),
        .SNAP_BYTES(SNAP_BYTES), .CNT_BYTES(CNT_BYTES)
    ) dut (
        .clk(clk), .rst(rst),
        .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
        .i_tx_done(i_tx_done), .i_snapshot(snap),
        .i_pc(pc), .i_halt(i_halt),
        .o_step(o_step), .o_pipe_rst_n(o_pipe_rst_n),
        .o_addr(o_addr), .o_instr(o_instr), .o_we(o_we),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .o_idle(o_idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int steps = 0;
    int wcount = 0;
    int tx_wait = -1;
    bit pc_clr = 1'b1;
    logic [7:0]  txq[$];
    logic [31:0] mem [0:255];

    // Observers: step cycles, memory writes, and a byte transmitter model.
    always @(negedge clk) begin
        if (o_step) steps++;
        if (o_we) begin
            mem[o_addr] = o_instr;
            wcount++;
        end
        i_tx_done = 1'b0;
        if (tx_wait > 0) tx_wait--;
        else if (tx_wait == 0) begin
            i_tx_done = 1'b1;
            tx_wait = -1;
        end
        if (o_tx_start) begin
            txq.push_back(o_tx_data);
            tx_wait = $urandom_range(0, 2);
        end
    end

    // Pipeline PC model: advances once per enabled pipeline cycle.
    always @(posedge clk) begin
        if (pc_clr) pc <= '0;
        else if (o_step) pc <= pc + 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1 i_rx_data = b;
        i_rx_done = 1'b1;
        @(posedge clk);
        #1 i_rx_done = 1'b0;
    endtask

    task automatic new_snap();
        for (int k = 0; k < SNAP_BYTES; k++) snap[8*k +: 8] = 8'($urandom);
    endtask

    task automatic wait_frame(input string name, input logic [31:0] exp_cnt,
                              input logic exp_idle);
        int n = 0;
        int bad = 0;
        int first = -1;
        logic [7:0] e;
        while (txq.size() < FB && n < 20000) begin
            @(posedge clk);
            n++;
        end
        repeat (8) @(posedge clk);
        #1;
        check({name, "_len"}, txq.size(), FB);
        for (int k = 0; k < FB && k < txq.size(); k++) begin
            e = (k < SNAP_BYTES) ? snap[8*k +: 8] : exp_cnt[8*(k-SNAP_BYTES) +: 8];
            if (txq[k] !== e) begin
                bad++;
                if (first < 0) first = k;
            end
        end
        if (bad != 0) $display("first bad frame byte index %0d", first);
        check({name, "_bytes_bad"}, bad, 0);
        check({name, "_end_idle"}, o_idle, exp_idle);
        txq.delete();
    endtask

    task automatic do_run(input int k);
        new_snap();
        txq.delete();
        steps = 0;
        if (k == 0) i_halt = 1'b1;
        send_byte(8'h02);
        check("run_prst", o_pipe_rst_n, 1'b1);
        if (k > 0) begin
            repeat (k) @(posedge clk);
            #1 i_halt = 1'b1;
            #1 check("step_gate", o_step, 1'b0);
        end
        wait_frame("run", k, 1'b1);
        check("run_steps", steps, k);
        i_halt = 1'b0;
    endtask

    task automatic do_load(input int n, input logic [7:0] data[$]);
        logic [31:0] exp_w;
        int bad = 0;
        wcount = 0;
        send_byte(8'h01);
        send_byte(8'(n));
        for (int w = 0; w < n; w++)
            for (int b = 0; b < INSTR_BYTES; b++)
                send_byte(data[w*INSTR_BYTES + b]);
        repeat (2) @(posedge clk);
        #1;
        check("load_writes", wcount, n);
        for (int w = 0; w < n; w++) begin
            for (int b = 0; b < INSTR_BYTES; b++)
                exp_w[8*b +: 8] = data[w*INSTR_BYTES + b];
            if (mem[w] !== exp_w) bad++;
        end
        check("load_words_bad", bad, 0);
        check("load_idle", o_idle, 1'b1);
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic       idle;
        logic       prst;
        bit         has_rec;
        logic [7:0] rec;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [7:0] d[$];
        int n;

        repeat (2) @(posedge clk);
        #1;
        check("rst_step", o_step, 1'b0);
        check("rst_prst", o_pipe_rst_n, 1'b0);
        check("rst_addr", o_addr, 0);
        check("rst_instr", o_instr, 0);
        check("rst_we", o_we, 1'b0);
        check("rst_txd", o_tx_data, 0);
        check("rst_txs", o_tx_start, 1'b0);
        check("rst_idle", o_idle, 1'b1);
        rst = 1'b1;
        pc_clr = 1'b0;

        tbl.push_back('{8'h00, 1'b1, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{8'h7F, 1'b1, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{8'hFF, 1'b1, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{8'h06, 1'b1, 1'b0, 1'b0, 8'h00});
`ifndef DBG_BREAKPOINT_EN
        tbl.push_back('{8'h04, 1'b1, 1'b0, 1'b0, 8'h00});
`endif
        tbl.push_back('{8'h01, 1'b0, 1'b0, 1'b1, 8'h00});
        tbl.push_back('{8'h03, 1'b0, 1'b1, 1'b1, 8'h06});
        foreach (tbl[i]) begin
            send_byte(tbl[i].cmd);
            check($sformatf("vec%0d_idle", i), o_idle, tbl[i].idle);
            check($sformatf("vec%0d_prst", i), o_pipe_rst_n, tbl[i].prst);
            check($sformatf("vec%0d_step", i), o_step, 1'b0);
            if (tbl[i].has_rec) begin
                send_byte(tbl[i].rec);
                check($sformatf("vec%0d_back", i), o_idle, 1'b1);
            end
        end

        // Two-word load with write-strobe timing.
        wcount = 0;
        send_byte(8'h01);
        send_byte(8'h02);
        for (int b = 0; b < 8; b++) begin
            send_byte(8'h11 + 8'(b));
            if (b == 3 || b == 7) begin
                check("ld_we", o_we, 1'b1);
                check("ld_addr", o_addr, (b == 3) ? 0 : 1);
                check("ld_data", o_instr, (b == 3) ? 32'h14131211 : 32'h18171615);
            end else begin
                check("ld_prst", o_pipe_rst_n, 1'b0);
            end
        end
        @(posedge clk);
        #1 check("ld_done_idle", o_idle, 1'b1);
        check("ld_wcount", wcount, 2);

        wcount = 0;
        send_byte(8'h01);
        send_byte(8'h00);
        check("ld_zero_idle", o_idle, 1'b1);
        check("ld_zero_we", wcount, 0);

        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 6);
            d.delete();
            for (int k = 0; k < n * INSTR_BYTES; k++) d.push_back(8'($urandom));
            do_load(n, d);
        end

        do_run(37);
        do_run(0);
        for (int r = 0; r < 2; r++) do_run($urandom_range(1, 80));

        // Step mode: two steps, ignored byte, exit, then halted step.
        new_snap();
        txq.delete();
        steps = 0;
        send_byte(8'h03);
        check("st_enter", o_idle, 1'b0);
        send_byte(8'h03);
        check("st_pulse", o_step, 1'b1);
        wait_frame("st1", 1, 1'b0);
        check("st1_steps", steps, 1);
        send_byte(8'h03);
        wait_frame("st2", 2, 1'b0);
        check("st2_steps", steps, 2);
        send_byte(8'h07);
        check("st_ign", o_idle, 1'b0);
        send_byte(8'h06);
        check("st_exit", o_idle, 1'b1);
        check("st_no_frame", txq.size(), 0);

        steps = 0;
        send_byte(8'h03);
        i_halt = 1'b1;
        send_byte(8'h03);
        wait_frame("st_halt", 0, 1'b1);
        check("st_halt_steps", steps, 0);
        i_halt = 1'b0;

`ifdef DBG_BREAKPOINT_EN
        new_snap();
        txq.delete();
        steps = 0;
        pc_clr = 1'b1;
        @(posedge clk);
        #1 pc_clr = 1'b0;
        send_byte(8'h04);
        send_byte(8'h0A);
        wait_frame("bp", 10, 1'b1);
        check("bp_pc", pc, 10);
        check("bp_steps", steps, 10);
`endif

        // Reset mid-frame.
        new_snap();
        txq.delete();
        i_halt = 1'b1;
        send_byte(8'h02);
        n = 0;
        while (txq.size() < 5 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        #1 rst = 1'b0;
        check("mid_seen5", txq.size(), 5);
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_txs", o_tx_start, 1'b0);
        check("mid_rst_idle", o_idle, 1'b1);
        rst = 1'b1;
        i_halt = 1'b0;
        repeat (20) @(posedge clk);
        #1 check("mid_no_more", txq.size(), 5);
        send_byte(8'h7F);
        check("mid_7f_idle", o_idle, 1'b1);
        check("mid_7f_prst", o_pipe_rst_n, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
